div_ctrl: RTL
=============

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32, operand/result width.
REQ-002 SHALL have parameter TMO, default 63, max cycles waited on divider ready before timeout (1..255).
REQ-003 SHALL have ports: clk_i input 1 clock; rst_ni input 1 reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports: req_i input 1 divide request; signed_i input 1 signed operation; A_i input DW dividend; B_i input DW divisor.
REQ-005 SHALL have ports: busy_o output 1 op in progress; done_o output 1 one-cycle completion pulse; quotient_o output DW; remainder_o output DW; dz_o output 1 divide-by-zero flag; err_o output 1 timeout flag.
REQ-006 SHALL have ports: div_start_o output 1; div_A_o output DW; div_B_o output DW; div_ready_i input 1; div_quotient_i input DW; div_remainder_i input DW (unsigned pipelined divider side).

Function
REQ-007 SHALL implement FSM IDLE -> ISSUE -> ARM -> WAIT -> DONE -> IDLE.
REQ-008 IDLE: req_i=1 SHALL register A_i, B_i and signed_i, and go to ISSUE next cycle; busy_o=0 only in IDLE.
REQ-009 IDLE with req_i=1 and B_i=0 SHALL go to DONE directly: quotient all ones, remainder=A_i, dz_o=1, divider not started.
REQ-010 ISSUE: div_start_o=1 for exactly one cycle; div_A_o/div_B_o SHALL carry operand magnitudes (unsigned: raw operands) and hold stable until DONE.
REQ-011 ARM: one guard cycle, div_ready_i ignored, because divider ready drops one cycle after start.
REQ-012 WAIT: first cycle with div_ready_i=1 SHALL capture div_quotient_i/div_remainder_i and go to DONE.
REQ-013 WAIT: 8-bit counter SHALL count WAIT cycles; reaching TMO with div_ready_i=0 SHALL go to DONE with err_o=1, quotient_o=0, remainder_o=0.
REQ-014 DONE: done_o=1 for one cycle; then IDLE; quotient_o, remainder_o, dz_o and err_o SHALL hold until the next accepted request clears them.
REQ-015 req_i outside IDLE SHALL be ignored (no queuing); a req_i in the same cycle as DONE SHALL be ignored.
REQ-016 Sign fix-up (see Configuration) SHALL be applied in the capture cycle; the results SHALL be registered, with no combinational path from div_*_i to outputs.
REQ-017 Total latency, request to done_o, SHALL be divider latency + 4 cycles; divide-by-zero SHALL take 2 cycles.

Reset
REQ-018 rst_ni=0 SHALL asynchronously force IDLE, with all outputs, counter and operand registers 0.
REQ-019 Reset mid-operation SHALL abort without a done_o pulse; any stale divider ready after reset SHALL be ignored, because FSM is in IDLE.

Configuration
REQ-020 Macro DIV_CTRL_SIGNED_EN defined: signed_i=1 SHALL send |A|,|B| to the divider, negate quotient if operand signs differ, and give remainder the dividend's sign.
REQ-021 Signed edge case: min-negative / -1 SHALL yield quotient min-negative (wrap), remainder 0.
REQ-022 Macro DIV_CTRL_SIGNED_EN not defined: signed_i SHALL be ignored, all operations unsigned, and no negation logic built.

Verification
REQ-023 Unsigned 100/7, divider ready after 32 cycles -> quotient_o=14, remainder_o=2, done_o single pulse at cycle 36.
REQ-024 A=5, B=0 -> done_o after 2 cycles, quotient_o=0xFFFFFFFF, remainder_o=5, dz_o=1, div_start_o never asserted.
REQ-025 With DIV_CTRL_SIGNED_EN, signed -100/7 -> quotient_o=-14, remainder_o=-2; 0x80000000/-1 -> quotient_o=0x80000000, remainder_o=0.
REQ-026 div_ready_i held 0 -> err_o=1 and done_o after TMO WAIT cycles, quotient_o=0; a request while busy_o=1 produces no second div_start_o.
REQ-027 rst_ni pulsed low in WAIT -> all outputs 0 immediately, no done_o; a new request after reset completes correctly.

Source files
------------

// File: rtl/div_ctrl.sv
// Sequencer between a request/response client and an unsigned pipelined divider.
// Define DIV_CTRL_SIGNED_EN to add signed operation through magnitude/sign fix-up.
module div_ctrl #(
  parameter int unsigned DW  = 32,
  parameter int unsigned TMO = 63
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  input  logic          signed_i,
  input  logic [DW-1:0] A_i,
  input  logic [DW-1:0] B_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] quotient_o,
  output logic [DW-1:0] remainder_o,
  output logic          dz_o,
  output logic          err_o,
  output logic          div_start_o,
  output logic [DW-1:0] div_A_o,
  output logic [DW-1:0] div_B_o,
  input  logic          div_ready_i,
  input  logic [DW-1:0] div_quotient_i,
  input  logic [DW-1:0] div_remainder_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          start_q, start_d;
  logic          done_q, done_d;
  logic          dz_q, dz_d;
  logic          err_q, err_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] div_a_q, div_a_d;
  logic [DW-1:0] div_b_q, div_b_d;

  logic [DW-1:0] a_mag, b_mag;
  logic [DW-1:0] cap_quot, cap_rem;

`ifdef DIV_CTRL_SIGNED_EN
  logic a_neg, b_neg;
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  assign a_neg    = signed_i & A_i[DW-1];
  assign b_neg    = signed_i & B_i[DW-1];
  assign a_mag    = a_neg ? -A_i : A_i;
  assign b_mag    = b_neg ? -B_i : B_i;
  // Most-negative / -1 wraps back to most-negative through the same negation.
  assign cap_quot = qneg_q ? -div_quotient_i : div_quotient_i;
  assign cap_rem  = rneg_q ? -div_remainder_i : div_remainder_i;
`else
  logic unused_signed;

  assign unused_signed = signed_i;
  assign a_mag    = A_i;
  assign b_mag    = B_i;
  assign cap_quot = div_quotient_i;
  assign cap_rem  = div_remainder_i;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    err_d   = err_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
`ifdef DIV_CTRL_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          cnt_d   = '0;
          dz_d    = 1'b0;
          err_d   = 1'b0;
          quot_d  = '0;
          rem_d   = '0;
          div_a_d = a_mag;
          div_b_d = b_mag;
`ifdef DIV_CTRL_SIGNED_EN
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
`endif
          if (B_i == '0) begin
            quot_d  = '1;
            rem_d   = A_i;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_ARM;
      S_ARM:   state_d = S_WAIT;
      S_WAIT: begin
        if (div_ready_i) begin
          quot_d  = cap_quot;
          rem_d   = cap_rem;
          state_d = S_DONE;
        end else if (cnt_q == 8'(TMO - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d != S_IDLE);
    start_d = (state_d == S_ISSUE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      err_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      div_a_q <= '0;
      div_b_q <= '0;
`ifdef DIV_CTRL_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      err_q   <= err_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
`ifdef DIV_CTRL_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;
  assign dz_o        = dz_q;
  assign err_o       = err_q;
  assign div_start_o = start_q;
  assign div_A_o     = div_a_q;
  assign div_B_o     = div_b_q;

endmodule
